// File: rtl/uart_msg_tx.sv
// uart_msg_tx: streams a message of bytes from an external synchronous memory
// out as UART frames (start bit, 8 data bits LSB first, optional parity,
// STOP_BITS stop bits). The next byte is prefetched during the stop bits so
// frames follow each other with no idle gap.
// Optional feature: define UART_PARITY_EN to insert a parity bit after D7.
module uart_msg_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 6,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   msg_len,
  input  logic                  abort,
  output logic                  ready,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_rdata,
  output logic                  uart_tx
);

  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = $clog2((2 ** ADDR_WIDTH) + 1);
  localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START_BIT, DATA, PARITY, STOP} state_t;

  function automatic logic frame_parity(input logic [7:0] b);
    return (^b) ^ PARITY_ODD;
  endfunction

  logic par_q, par_d;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START_BIT, DATA, STOP} state_t;

  // Parity sense has no meaning when frames carry no parity bit.
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  state_t                state_q, state_d;
  logic [CLK_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;
  logic                  uart_tx_q, uart_tx_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [7:0]            shift_q, shift_d;

  logic bit_end;
  logic last_byte;

  assign bit_end   = (clk_cnt_q == CLK_LAST);
  assign last_byte = (rem_q == CNT_W'(1));

  // Next-state, counter and line-level logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    rem_d       = rem_q;
    mem_raddr_d = mem_raddr_q;
    uart_tx_d   = uart_tx_q;
    done_d      = 1'b0;
    abort_d     = abort_q | abort;
    shift_d     = shift_q;
`ifdef UART_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        abort_d   = 1'b0;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        uart_tx_d = 1'b1;
        if (start) begin
          if (msg_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = FETCH;
            mem_raddr_d = base_addr;
            rem_d       = CNT_W'(msg_len);
          end
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort || abort_q) begin
          state_d = IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d   = START_BIT;
          shift_d   = mem_rdata;
`ifdef UART_PARITY_EN
          par_d     = frame_parity(mem_rdata);
`endif
          uart_tx_d = 1'b0;
          clk_cnt_d = '0;
        end
      end
      START_BIT: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
          uart_tx_d = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d   = PARITY;
            uart_tx_d = par_q;
`else
            state_d   = STOP;
            uart_tx_d = 1'b1;
            if (!last_byte) mem_raddr_d = mem_raddr_q + 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            uart_tx_d = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = STOP;
          uart_tx_d = 1'b1;
          if (!last_byte) mem_raddr_d = mem_raddr_q + 1'b1;
        end
      end
`endif
      STOP: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        // Prefetched byte is valid in the second cycle of the first stop bit.
        if (bit_cnt_q == '0 && clk_cnt_q == CLK_W'(1)) begin
          shift_d = mem_rdata;
`ifdef UART_PARITY_EN
          par_d   = frame_parity(mem_rdata);
`endif
        end
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (last_byte || abort_q || abort) begin
              state_d = IDLE;
              rem_d   = '0;
              done_d  = 1'b1;
            end else begin
              rem_d     = rem_q - 1'b1;
              state_d   = START_BIT;
              uart_tx_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        uart_tx_d = 1'b1;
      end
    endcase
  end

  // Control state; async reset drives the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      rem_q       <= '0;
      mem_raddr_q <= '0;
      uart_tx_q   <= 1'b1;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rem_q       <= rem_d;
      mem_raddr_q <= mem_raddr_d;
      uart_tx_q   <= uart_tx_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  // Byte shifter (data only, no reset needed).
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign mem_raddr = mem_raddr_q;
  assign uart_tx   = uart_tx_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Testbench for uart_msg_tx: a frame decoder on uart_tx pops expected bytes
// from a scoreboard queue filled when each message is started.
module tb_uart_msg_tx;

  localparam int CPB = 4;
  localparam int AW  = 6;
`ifdef UART_PARITY_EN
  localparam int SB  = 2;
  localparam bit ODD = 1'b1;
  localparam int PAR = 1;
`else
  localparam int SB  = 1;
  localparam bit ODD = 1'b0;
  localparam int PAR = 0;
`endif
  localparam int F   = 9 + PAR + SB;
  localparam int FC  = F * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   msg_len;
  logic          abort;
  logic          ready;
  logic          done;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_rdata;
  logic          uart_tx;

  logic [7:0] mem [64];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]    exp_q[$];
  int            start_q[$];
  logic [AW-1:0] raddr_q[$];

  int      t_done, n_done, line_low;
  logic    rdy_done, r1_ready, tx3, last_par;
  logic [AW-1:0] r1_raddr;

  uart_msg_tx #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .STOP_BITS(SB), .PARITY_ODD(ODD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .msg_len(msg_len),
    .abort(abort), .ready(ready), .done(done), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem[mem_raddr];
  end

  // Frame decoder and scoreboard consumer.
  initial begin : monitor
    logic [15:0] bits;
    logic stable, lost, stop_ok;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        bits = '0; stable = 1'b1; lost = 1'b0;
        for (int b = 0; b < F; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst !== 1'b0) lost = 1'b1;
            if (lost) break;
            if (c == 0) bits[b] = uart_tx;
            else if (uart_tx !== bits[b]) stable = 1'b0;
          end
          if (lost) break;
        end
        if (!lost) begin
          n_checks++;
          if (!stable) begin
            n_errors++;
            $display("FAIL frame_bit_width: line changed inside a bit period (frame ending cycle %0d), required constant", cyc);
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL frame_data: got unexpected frame 0x%02h, required no frame", bits[8:1]);
          end else begin
            e = exp_q.pop_front();
            if (bits[8:1] !== e) begin
              n_errors++;
              $display("FAIL frame_data: got 0x%02h, required 0x%02h", bits[8:1], e);
            end
`ifdef UART_PARITY_EN
            last_par = bits[9];
            n_checks++;
            if (bits[9] !== ((^e) ^ ODD)) begin
              n_errors++;
              $display("FAIL frame_parity: got %b, required %b", bits[9], (^e) ^ ODD);
            end
`endif
          end
          stop_ok = 1'b1;
          for (int s = 0; s < SB; s++) if (bits[9 + PAR + s] !== 1'b1) stop_ok = 1'b0;
          n_checks++;
          if (!stop_ok) begin
            n_errors++;
            $display("FAIL frame_stop: got stop bits not all 1, required 1");
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a message in the current cycle (T) and observes until done+2.
  task automatic send_msg(input logic [AW-1:0] base, input logic [AW:0] len, input int n_push,
                          input int abort_at, input int restart_at, input int budget);
    for (int i = 0; i < n_push; i++) exp_q.push_back(mem[(int'(base) + i) % 64]);
    start_q.delete();
    raddr_q.delete();
    t_done = -1; n_done = 0; line_low = 0; rdy_done = 1'b0;
    base_addr = base; msg_len = len; start = 1'b1; abort = (abort_at == 0);
    tick();
    for (int k = 1; k <= budget; k++) begin
      start = (k == restart_at);
      abort = (k == abort_at);
      if (k == 1) begin
        r1_ready = ready; r1_raddr = mem_raddr; raddr_q.push_back(mem_raddr);
      end else if (mem_raddr !== raddr_q[$]) begin
        raddr_q.push_back(mem_raddr);
      end
      if (k == 3) tx3 = uart_tx;
      if (uart_tx !== 1'b1) line_low++;
      if (done === 1'b1) begin
        n_done++;
        if (t_done < 0) begin t_done = k; rdy_done = ready; end
      end
      if (t_done >= 0 && k >= t_done + 2) break;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b, required 0", done); end
    n_checks++; if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
    n_checks++; if (mem_raddr !== '0) begin n_errors++; $display("FAIL reset_raddr: got %0d, required 0", mem_raddr); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43;
    send_msg(6'd0, 7'd3, 3, -1, -1, 3 + 3 * FC + 20);
    n_checks++; if (r1_ready !== 1'b0) begin n_errors++; $display("FAIL basic_ready_t1: got %b, required 0", r1_ready); end
    n_checks++; if (r1_raddr !== 6'd0) begin n_errors++; $display("FAIL basic_raddr_t1: got %0d, required 0", r1_raddr); end
    n_checks++; if (tx3 !== 1'b0) begin n_errors++; $display("FAIL basic_tx_t3: got %b, required 0", tx3); end
    n_checks++; if (t_done != 3 + 3 * FC) begin n_errors++; $display("FAIL basic_done_time: got T+%0d, required T+%0d", t_done, 3 + 3 * FC); end
    n_checks++; if (rdy_done !== 1'b1) begin n_errors++; $display("FAIL basic_ready_at_done: got %b, required 1", rdy_done); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL basic_done_pulses: got %0d, required 1", n_done); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL basic_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want [4];
    want[0] = 6'd62; want[1] = 6'd63; want[2] = 6'd0; want[3] = 6'd1;
    send_msg(6'd62, 7'd4, 4, -1, -1, 3 + 4 * FC + 20);
    n_checks++;
    if (raddr_q.size() != 4) begin
      n_errors++; $display("FAIL wrap_raddr_count: got %0d, required 4", raddr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (raddr_q[i] !== want[i]) begin n_errors++; $display("FAIL wrap_raddr[%0d]: got %0d, required %0d", i, raddr_q[i], want[i]); end
      end
    end
    n_checks++;
    if (start_q.size() != 4) begin
      n_errors++; $display("FAIL wrap_frames: got %0d, required 4", start_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (start_q[i] - start_q[i-1] != FC) begin n_errors++; $display("FAIL wrap_gap[%0d]: got %0d, required %0d", i, start_q[i] - start_q[i-1], FC); end
      end
    end
    n_checks++; if (t_done != 3 + 4 * FC) begin n_errors++; $display("FAIL wrap_done_time: got T+%0d, required T+%0d", t_done, 3 + 4 * FC); end
  endtask

  task automatic test_zero_len();
    send_msg(6'd7, 7'd0, 0, -1, -1, 12);
    n_checks++; if (t_done != 1) begin n_errors++; $display("FAIL zero_done_time: got T+%0d, required T+1", t_done); end
    n_checks++; if (rdy_done !== 1'b1) begin n_errors++; $display("FAIL zero_ready: got %b, required 1", rdy_done); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL zero_done_pulses: got %0d, required 1", n_done); end
    repeat (FC) begin tick(); if (uart_tx !== 1'b1) line_low++; end
    n_checks++; if (line_low != 0) begin n_errors++; $display("FAIL zero_line: got %0d low cycles, required 0", line_low); end
  endtask

  task automatic test_ignore_start();
    int extra;
    send_msg(6'd10, 7'd1, 1, -1, 5, 3 + FC + 20);
    n_checks++; if (t_done != 3 + FC) begin n_errors++; $display("FAIL ignore_done_time: got T+%0d, required T+%0d", t_done, 3 + FC); end
    extra = 0;
    repeat (FC + 10) begin tick(); if (uart_tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) extra++; end
    n_checks++; if (extra != 0) begin n_errors++; $display("FAIL ignore_no_requeue: got %0d busy cycles, required 0", extra); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL ignore_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int busy;
    send_msg(6'd20, 7'd5, 2, 3 + FC + 4 * CPB + 1, -1, 3 + 5 * FC + 20);
    n_checks++; if (t_done != 3 + 2 * FC) begin n_errors++; $display("FAIL abort_done_time: got T+%0d, required T+%0d", t_done, 3 + 2 * FC); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL abort_done_pulses: got %0d, required 1", n_done); end
    busy = 0;
    repeat (FC + 10) begin tick(); if (uart_tx !== 1'b1 || ready !== 1'b1) busy++; end
    n_checks++; if (busy != 0) begin n_errors++; $display("FAIL abort_idle_after: got %0d busy cycles, required 0", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL abort_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_abort_first();
    for (int a = 1; a <= 2; a++) begin
      send_msg(6'd33, 7'd3, 0, a, -1, 20);
      n_checks++; if (t_done != a + 1) begin n_errors++; $display("FAIL abort_first_done_time[%0d]: got T+%0d, required T+%0d", a, t_done, a + 1); end
      n_checks++; if (line_low != 0) begin n_errors++; $display("FAIL abort_first_line[%0d]: got %0d low cycles, required 0", a, line_low); end
      tick();
    end
  endtask

  task automatic test_full_len();
    send_msg(6'd5, 7'd64, 64, -1, -1, 3 + 64 * FC + 20);
    n_checks++; if (t_done != 3 + 64 * FC) begin n_errors++; $display("FAIL full_done_time: got T+%0d, required T+%0d", t_done, 3 + 64 * FC); end
    n_checks++; if (raddr_q.size() != 64) begin n_errors++; $display("FAIL full_raddr_count: got %0d, required 64", raddr_q.size()); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL full_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    mem[20] = 8'h00;
    mem[30] = 8'h5A; mem[31] = 8'hC3;
    base_addr = 6'd20; msg_len = 7'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3 + 4 * CPB) tick();
    n_checks++; if (uart_tx !== 1'b0) begin n_errors++; $display("FAIL rstmid_pre_tx: got %b, required 0", uart_tx); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL rstmid_async_tx: got %b, required 1", uart_tx); end
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %b, required 1", ready); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b, required 0", done); end
    n_checks++; if (mem_raddr !== '0) begin n_errors++; $display("FAIL rstmid_raddr: got %0d, required 0", mem_raddr); end
    rst = 1'b0;
    send_msg(6'd30, 7'd2, 2, -1, -1, 3 + 2 * FC + 20);
    n_checks++; if (r1_raddr !== 6'd30 || r1_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_first_start: got raddr %0d ready %b, required raddr 30 ready 0", r1_raddr, r1_ready); end
    n_checks++; if (t_done != 3 + 2 * FC) begin n_errors++; $display("FAIL rstmid_done_time: got T+%0d, required T+%0d", t_done, 3 + 2 * FC); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rstmid_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    mem[40] = 8'h03;
    send_msg(6'd40, 7'd1, 1, -1, -1, 3 + FC + 20);
    n_checks++; if (last_par !== 1'b1) begin n_errors++; $display("FAIL parity_bit: got %b, required 1", last_par); end
    n_checks++; if (t_done != 3 + 48) begin n_errors++; $display("FAIL parity_frame_time: got T+%0d, required T+51", t_done); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; msg_len = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_ignore_start();
    test_abort();
    test_abort_first();
    test_full_len();
    test_reset_mid();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
